// File: rtl/excp_flush_sched.sv
// Purpose : exception/ERTN redirect sequencer for the dual-issue core. Picks the
//           oldest pending event (slot-1 exception, then ERTN, then slot-2
//           exception), latches EPC/ECODE, then runs a timed flush with a
//           one-cycle redirect pulse. It also merges the per-slot stall requests.
// Latency : flush/redirect assert the cycle after the event is sampled. Flush
//           holds for FLUSH_CYCLES cycles. Stall vectors are combinational.
// Backpr. : none. Events that arrive while a flush is running are dropped,
//           because they belong to instructions being flushed.
// Ports   : clk/rst_n (sync, active-low); excp_valid/code/pc per slot; ertn_i
//           (slot 1); stallreq_from_id/ex per slot -> flush, new_pc,
//           redirect_valid, stall1/stall2, epc_o, ecode_o, in_excp, busy.
module excp_flush_sched #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_ENTRY    = 32'h0000000c
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        excp_valid_1,
  input  logic [5:0]  excp_code_1,
  input  logic [31:0] excp_pc_1,
  input  logic        excp_valid_2,
  input  logic [5:0]  excp_code_2,
  input  logic [31:0] excp_pc_2,
  input  logic        ertn_i,
  input  logic        stallreq_from_id_1,
  input  logic        stallreq_from_ex_1,
  input  logic        stallreq_from_id_2,
  input  logic        stallreq_from_ex_2,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        redirect_valid,
  output logic [6:0]  stall1,
  output logic [6:0]  stall2,
  output logic [31:0] epc_o,
  output logic [5:0]  ecode_o,
  output logic        in_excp,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [6:0] STALL_VEC = 7'b0011111;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        redir_q, redir_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] epc_q, epc_d;
  logic [5:0]  ecode_q, ecode_d;
  logic        in_excp_q, in_excp_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      flush_q   <= 1'b0;
      redir_q   <= 1'b0;
      new_pc_q  <= 32'd0;
      epc_q     <= 32'd0;
      ecode_q   <= 6'd0;
      in_excp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      redir_q   <= redir_d;
      new_pc_q  <= new_pc_d;
      epc_q     <= epc_d;
      ecode_q   <= ecode_d;
      in_excp_q <= in_excp_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flush_d   = flush_q;
    redir_d   = redir_q;
    new_pc_d  = new_pc_q;
    epc_d     = epc_q;
    ecode_d   = ecode_q;
    in_excp_d = in_excp_q;

    unique case (state_q)
      IDLE: begin
        // Slot 1 is older than slot 2, so it wins. ERTN sits in slot 1, so it
        // also beats a slot-2 exception, which the ERTN flush then kills.
        if (excp_valid_1 || ertn_i || excp_valid_2) begin
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
          flush_d = 1'b1;
          redir_d = 1'b1;
          if (excp_valid_1) begin
            epc_d     = excp_pc_1;
            ecode_d   = excp_code_1;
            in_excp_d = 1'b1;
            new_pc_d  = EXC_ENTRY;
          end else if (ertn_i) begin
            // Return to the EPC latched before this edge. This happens even if
            // no handler is active.
            new_pc_d  = epc_q;
            in_excp_d = 1'b0;
          end else begin
            epc_d     = excp_pc_2;
            ecode_d   = excp_code_2;
            in_excp_d = 1'b1;
            new_pc_d  = EXC_ENTRY;
          end
        end
      end
      FLUSH: begin
        redir_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d  = IDLE;
          flush_d  = 1'b0;
          new_pc_d = 32'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  logic s1, s2;
  always_comb begin
    s1 = stallreq_from_ex_1 | stallreq_from_id_1;
    s2 = stallreq_from_ex_2 | stallreq_from_id_2;

    stall1 = 7'd0;
    stall2 = 7'd0;
    // A flush discards the stalled instructions, so it overrides any stall.
    if (rst_n && !flush_q) begin
      if (s1)
        stall1 = STALL_VEC;
      // The younger slot must never move past a stalled older slot.
      if (s1 || s2)
        stall2 = STALL_VEC;
    end

    flush          = flush_q;
    new_pc         = new_pc_q;
    redirect_valid = redir_q;
    epc_o          = epc_q;
    ecode_o        = ecode_q;
    in_excp        = in_excp_q;
    busy           = (state_q == FLUSH);
  end

endmodule

// File: tb/tb_excp_flush_sched.sv
module tb_excp_flush_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        excp_valid_1, excp_valid_2, ertn_i;
  logic [5:0]  excp_code_1, excp_code_2;
  logic [31:0] excp_pc_1, excp_pc_2;
  logic        stallreq_from_id_1, stallreq_from_ex_1;
  logic        stallreq_from_id_2, stallreq_from_ex_2;
  logic        flush, redirect_valid, in_excp, busy;
  logic [31:0] new_pc, epc_o;
  logic [6:0]  stall1, stall2;
  logic [5:0]  ecode_o;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] SV = 32'h1f;

  excp_flush_sched #(.FLUSH_CYCLES(2), .EXC_ENTRY(32'h0000000c)) dut (
    .clk(clk), .rst_n(rst_n),
    .excp_valid_1(excp_valid_1), .excp_code_1(excp_code_1), .excp_pc_1(excp_pc_1),
    .excp_valid_2(excp_valid_2), .excp_code_2(excp_code_2), .excp_pc_2(excp_pc_2),
    .ertn_i(ertn_i),
    .stallreq_from_id_1(stallreq_from_id_1), .stallreq_from_ex_1(stallreq_from_ex_1),
    .stallreq_from_id_2(stallreq_from_id_2), .stallreq_from_ex_2(stallreq_from_ex_2),
    .flush(flush), .new_pc(new_pc), .redirect_valid(redirect_valid),
    .stall1(stall1), .stall2(stall2), .epc_o(epc_o), .ecode_o(ecode_o),
    .in_excp(in_excp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    excp_valid_1 = 0; excp_valid_2 = 0; ertn_i = 0;
    excp_code_1 = 0; excp_code_2 = 0; excp_pc_1 = 0; excp_pc_2 = 0;
    stallreq_from_id_1 = 0; stallreq_from_ex_1 = 0;
    stallreq_from_id_2 = 0; stallreq_from_ex_2 = 0;
  endtask

  initial begin
    // Reset: hold rst_n low with every input asserted.
    rst_n = 0;
    excp_valid_1 = 1; excp_valid_2 = 1; ertn_i = 1;
    excp_code_1 = 6'h3f; excp_code_2 = 6'h3f;
    excp_pc_1 = 32'hffffffff; excp_pc_2 = 32'hffffffff;
    stallreq_from_id_1 = 1; stallreq_from_ex_1 = 1;
    stallreq_from_id_2 = 1; stallreq_from_ex_2 = 1;
    #1;
    tick(); tick();
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_new_pc", new_pc, 0);
    chk("rst_redir", {31'd0, redirect_valid}, 0);
    chk("rst_epc", epc_o, 0);
    chk("rst_ecode", {26'd0, ecode_o}, 0);
    chk("rst_in_excp", {31'd0, in_excp}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_stall1", {25'd0, stall1}, 0);
    chk("rst_stall2", {25'd0, stall2}, 0);
    idle_inputs();
    rst_n = 1;
    tick();
    chk("idle_flush", {31'd0, flush}, 0);

    // Slot-1 exception
    excp_valid_1 = 1; excp_pc_1 = 32'h1c000100; excp_code_1 = 6'h0b;
    tick();
    idle_inputs();
    chk("ex1_flush_c1", {31'd0, flush}, 1);
    chk("ex1_redir_c1", {31'd0, redirect_valid}, 1);
    chk("ex1_newpc_c1", new_pc, 32'h0000000c);
    chk("ex1_epc", epc_o, 32'h1c000100);
    chk("ex1_ecode", {26'd0, ecode_o}, 32'h0b);
    chk("ex1_in_excp", {31'd0, in_excp}, 1);
    chk("ex1_busy", {31'd0, busy}, 1);
    tick();
    chk("ex1_flush_c2", {31'd0, flush}, 1);
    chk("ex1_redir_c2", {31'd0, redirect_valid}, 0);
    chk("ex1_newpc_c2", new_pc, 32'h0000000c);
    tick();
    chk("ex1_flush_end", {31'd0, flush}, 0);
    chk("ex1_busy_end", {31'd0, busy}, 0);
    chk("ex1_newpc_end", new_pc, 0);
    chk("ex1_in_excp_end", {31'd0, in_excp}, 1);

    // ERTN after the exception
    ertn_i = 1;
    tick();
    idle_inputs();
    chk("ertn_flush", {31'd0, flush}, 1);
    chk("ertn_redir", {31'd0, redirect_valid}, 1);
    chk("ertn_newpc", new_pc, 32'h1c000100);
    chk("ertn_in_excp", {31'd0, in_excp}, 0);
    chk("ertn_epc", epc_o, 32'h1c000100);
    chk("ertn_ecode", {26'd0, ecode_o}, 32'h0b);
    tick();
    chk("ertn_flush_c2", {31'd0, flush}, 1);
    tick();
    chk("ertn_flush_end", {31'd0, flush}, 0);

    // Slot-1 and slot-2 exceptions together: slot 1 wins
    excp_valid_1 = 1; excp_pc_1 = 32'h100; excp_code_1 = 6'h01;
    excp_valid_2 = 1; excp_pc_2 = 32'h104; excp_code_2 = 6'h02;
    tick();
    idle_inputs();
    chk("both_epc", epc_o, 32'h100);
    chk("both_ecode", {26'd0, ecode_o}, 32'h01);
    tick(); tick();
    chk("both_done", {31'd0, busy}, 0);

    // ERTN and slot-2 exception together: ERTN wins
    ertn_i = 1;
    excp_valid_2 = 1; excp_pc_2 = 32'h200; excp_code_2 = 6'h05;
    tick();
    idle_inputs();
    chk("ertn2_newpc", new_pc, 32'h100);
    chk("ertn2_in_excp", {31'd0, in_excp}, 0);
    chk("ertn2_epc", epc_o, 32'h100);
    chk("ertn2_ecode", {26'd0, ecode_o}, 32'h01);
    tick(); tick();

    // Slot-1 exception and ERTN together: the exception wins
    excp_valid_1 = 1; excp_pc_1 = 32'h300; excp_code_1 = 6'h03; ertn_i = 1;
    tick();
    idle_inputs();
    chk("ex1ertn_epc", epc_o, 32'h300);
    chk("ex1ertn_in_excp", {31'd0, in_excp}, 1);
    chk("ex1ertn_newpc", new_pc, 32'h0000000c);
    tick(); tick();

    // A slot-2 exception asserted through both flush cycles is ignored
    excp_valid_1 = 1; excp_pc_1 = 32'h400; excp_code_1 = 6'h04;
    tick();
    idle_inputs();
    excp_valid_2 = 1; excp_pc_2 = 32'h500; excp_code_2 = 6'h07;
    tick();
    chk("inflush_epc_c2", epc_o, 32'h400);
    tick();
    idle_inputs();
    chk("inflush_epc", epc_o, 32'h400);
    chk("inflush_ecode", {26'd0, ecode_o}, 32'h04);
    chk("inflush_busy", {31'd0, busy}, 0);
    chk("inflush_flush", {31'd0, flush}, 0);

    // A lone slot-2 exception is accepted
    excp_valid_2 = 1; excp_pc_2 = 32'h600; excp_code_2 = 6'h06;
    tick();
    idle_inputs();
    chk("ex2_epc", epc_o, 32'h600);
    chk("ex2_ecode", {26'd0, ecode_o}, 32'h06);
    chk("ex2_newpc", new_pc, 32'h0000000c);
    tick(); tick();

    // ERTN twice: the second one runs with in_excp=0 and still redirects
    ertn_i = 1;
    tick();
    idle_inputs();
    tick(); tick();
    chk("ertn_a_in_excp", {31'd0, in_excp}, 0);
    ertn_i = 1;
    tick();
    idle_inputs();
    chk("ertn_b_flush", {31'd0, flush}, 1);
    chk("ertn_b_newpc", new_pc, 32'h600);
    tick(); tick();

    // Reset during the first flush cycle aborts the flush
    excp_valid_1 = 1; excp_pc_1 = 32'h700; excp_code_1 = 6'h08;
    tick();
    idle_inputs();
    chk("mid_flush_on", {31'd0, flush}, 1);
    rst_n = 0;
    tick();
    chk("mid_rst_flush", {31'd0, flush}, 0);
    chk("mid_rst_redir", {31'd0, redirect_valid}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_epc", epc_o, 0);
    rst_n = 1;
    tick();
    chk("mid_rst_after", {31'd0, flush}, 0);

    // Stall merge
    stallreq_from_id_2 = 1;
    #1;
    chk("st_id2_s1", {25'd0, stall1}, 0);
    chk("st_id2_s2", {25'd0, stall2}, SV);
    stallreq_from_id_2 = 0; stallreq_from_ex_1 = 1;
    #1;
    chk("st_ex1_s1", {25'd0, stall1}, SV);
    chk("st_ex1_s2", {25'd0, stall2}, SV);
    stallreq_from_ex_1 = 0; stallreq_from_ex_2 = 1;
    #1;
    chk("st_ex2_s1", {25'd0, stall1}, 0);
    chk("st_ex2_s2", {25'd0, stall2}, SV);
    stallreq_from_ex_2 = 0;
    excp_valid_1 = 1; excp_pc_1 = 32'h800; excp_code_1 = 6'h09;
    tick();
    idle_inputs();
    stallreq_from_ex_1 = 1;
    #1;
    chk("st_flush_s1", {25'd0, stall1}, 0);
    chk("st_flush_s2", {25'd0, stall2}, 0);
    tick(); tick();
    chk("st_after_s1", {25'd0, stall1}, SV);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
